// File: rtl/bus_wait_bridge_if.sv
// CPU-side and channel-side signals of the wait-state bus bridge.
// The bridge takes the slave modport; the CPU/peripheral side takes the master modport.
interface bus_wait_bridge_if #(
    parameter int NUM_CHANNELS  = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                               cpu_req_i;
    logic                               cpu_we_i;
    logic [ADDRESS_WIDTH-1:0]           cpu_address_i;
    logic [DATA_WIDTH-1:0]              cpu_data_i;
    logic [DATA_WIDTH-1:0]              cpu_data_o;
    logic                               cpu_halt_o;
    logic [NUM_CHANNELS-1:0]            ch_req_o;
    logic                               ch_we_o;
    logic [ADDRESS_WIDTH-1:0]           ch_address_o;
    logic [DATA_WIDTH-1:0]              ch_data_o;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data_i;
    logic [NUM_CHANNELS-1:0]            ch_ack_i;
    logic                               err_o;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_address_i, cpu_data_i, ch_data_i, ch_ack_i,
        output cpu_data_o, cpu_halt_o, ch_req_o, ch_we_o, ch_address_o, ch_data_o, err_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_address_i, cpu_data_i, ch_data_i, ch_ack_i,
        input  cpu_data_o, cpu_halt_o, ch_req_o, ch_we_o, ch_address_o, ch_data_o, err_o
    );
endinterface

// File: rtl/bus_wait_bridge.sv
// Single-clock N-channel CPU bus bridge with per-channel fixed wait states or ack handshake.
// Optional ack timeout enabled by defining BUS_WAIT_TIMEOUT_EN.
module bus_wait_bridge #(
    parameter int                                  NUM_CHANNELS  = 4,
    parameter int                                  ADDRESS_WIDTH = 32,
    parameter int                                  DATA_WIDTH    = 32,
    parameter int                                  WAIT_W        = 4,
    parameter logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] CH_BASE =
        {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] CH_LAST =
        {32'h0000_3FFF, 32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_0FFF},
    parameter logic [NUM_CHANNELS*WAIT_W-1:0]      CH_WAIT       = 16'h2222,
    parameter logic [NUM_CHANNELS-1:0]             ACK_MODE      = '0,
    parameter int                                  TIMEOUT_CYC   = 255,
    parameter logic [DATA_WIDTH-1:0]               TIMEOUT_DATA  = 32'hDEAD_BEEF
) (
    input  logic               clk_i,
    input  logic               reset_i,
    bus_wait_bridge_if.slave   bus
);
    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                   r_state, w_next;
    logic [IDX_W-1:0]         r_idx, w_hit_idx;
    logic                     w_hit, w_accept, w_ack, w_expire, w_timeout;
    logic [WAIT_W-1:0]        r_wait_cnt;
    logic                     r_we;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata, r_rdata;
    logic [NUM_CHANNELS-1:0]  w_ch_req;

    // Descending scan so the lowest matching channel is the one left in w_hit_idx.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = NUM_CHANNELS-1; k >= 0; k--) begin
            if (bus.cpu_address_i >= CH_BASE[k*ADDRESS_WIDTH +: ADDRESS_WIDTH] &&
                bus.cpu_address_i <= CH_LAST[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(k);
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && bus.cpu_req_i && w_hit;
    assign w_ack    = bus.ch_ack_i[r_idx];

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (ACK_MODE[r_idx]) begin
                    if (w_ack) begin
                        w_next = S_DONE;
                    end else if (w_expire) begin
                        w_next    = S_DONE;
                        w_timeout = 1'b1;
                    end
                end else if (r_wait_cnt == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_wait_cnt <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx      <= w_hit_idx;
                r_we       <= bus.cpu_we_i;
                r_addr     <= bus.cpu_address_i;
                r_wdata    <= bus.cpu_data_i;
                r_wait_cnt <= CH_WAIT[w_hit_idx*WAIT_W +: WAIT_W];
            end else if (r_state == S_WAIT && r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
            end
            if (r_state == S_WAIT && w_next == S_DONE && !r_we) begin
                r_rdata <= w_timeout ? TIMEOUT_DATA
                                     : bus.ch_data_i[r_idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef BUS_WAIT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    // Counts WAIT cycles of an ack-mode access; expiry fires in the TIMEOUT_CYC-th one.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state != S_WAIT) begin
                r_to_cnt <= '0;
            end else if (ACK_MODE[r_idx]) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign w_expire   = (r_state == S_WAIT) && ACK_MODE[r_idx] &&
                        (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign bus.err_o  = r_err;
`else
    // Timeout length is inert without the feature.
    logic w_unused_timeout_cyc;
    assign w_unused_timeout_cyc = ^TIMEOUT_CYC;
    assign w_expire  = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    always_comb begin
        w_ch_req = '0;
        if (r_state == S_ISSUE) w_ch_req[r_idx] = 1'b1;
    end

    assign bus.cpu_halt_o   = (r_state == S_ISSUE) || (r_state == S_WAIT) || w_accept;
    assign bus.ch_req_o     = w_ch_req;
    assign bus.ch_we_o      = r_we;
    assign bus.ch_address_o = r_addr;
    assign bus.ch_data_o    = r_wdata;
    assign bus.cpu_data_o   = r_rdata;
endmodule
